lcd_record_scheduler: RTL and testbench

//  Sits between the stopwatch key FSM and lcd_bridge. Accepts lap-record and clear requests at any time.

---
 rtl/lcd_record_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_lcd_record_scheduler.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_record_scheduler.sv
// Lap-record scheduler in front of lcd_bridge: queues BCD lap records and issues
// them, or a pending LCD clear, one command at a time whenever the bridge is idle.
module lcd_record_scheduler #(
    parameter int REC_W       = 32,
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       lap_req,
    input  logic [REC_W-1:0]           lap_record,
    input  logic                       clear_req,
    input  logic                       lcd_busy,
    output logic                       insert,
    output logic [REC_W-1:0]           new_record,
    output logic                       clear,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       overflow,
    output logic                       busy
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_ACK  = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [REC_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             clear_latch_r;
    logic [TMR_W-1:0] timer_r;
    logic             insert_r;
    logic             clear_r;
    logic [REC_W-1:0] new_record_r;
    logic             overflow_r;
    logic             busy_r;

    logic             clear_pend_s;
    logic             lap_ok_s;
    logic             idle_s;
    logic             issue_clear_s;
    logic             issue_insert_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic [REC_W-1:0] head_s;

    logic [1:0]       state_next_s;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [CNT_W-1:0] count_next_s;
    logic             clear_latch_next_s;
    logic [TMR_W-1:0] timer_next_s;
    logic [REC_W-1:0] new_record_next_s;
    logic             overflow_next_s;
    logic             busy_next_s;

    // Command selection and FIFO handshake; a request arriving while idle is
    // served in the same cycle so its pulse lands one cycle after the request.
    always_comb begin
        clear_pend_s   = clear_latch_r | clear_req;
        lap_ok_s       = lap_req & ~clear_req;
        idle_s         = (state_r == IDLE);
        issue_clear_s  = idle_s & clear_pend_s & ~lcd_busy;
        issue_insert_s = idle_s & ~clear_pend_s & ~lcd_busy &
                         ((count_r != {CNT_W{1'b0}}) | lap_ok_s);
        pop_s          = issue_insert_s;
        full_s         = (count_r == CNT_W'(DEPTH));
        push_s         = lap_ok_s & (~full_s | pop_s);
        drop_s         = lap_ok_s & ~push_s;
        if (count_r != {CNT_W{1'b0}}) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = lap_record;
        end
    end

    // Next-state for the FSM, FIFO bookkeeping and the registered outputs.
    always_comb begin
        state_next_s       = state_r;
        timer_next_s       = timer_r;
        wr_ptr_next_s      = wr_ptr_r;
        rd_ptr_next_s      = rd_ptr_r;
        count_next_s       = count_r;
        clear_latch_next_s = clear_latch_r;
        overflow_next_s    = overflow_r;
        new_record_next_s  = new_record_r;

        case (state_r)
            IDLE: begin
                if (issue_clear_s || issue_insert_s) begin
                    state_next_s = WAIT_ACK;
                    timer_next_s = {TMR_W{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_ACK: begin
                if (lcd_busy) begin
                    state_next_s = WAIT_DONE;
                end else if (timer_r == TMR_W'(ACK_TIMEOUT - 1)) begin
                    // Bridge never acknowledged; treat the command as complete.
                    state_next_s = IDLE;
                end else begin
                    timer_next_s = timer_r + TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!lcd_busy) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        if (clear_req) begin
            wr_ptr_next_s = {PTR_W{1'b0}};
            rd_ptr_next_s = {PTR_W{1'b0}};
            count_next_s  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
            if (push_s && !pop_s) begin
                count_next_s = count_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_next_s = count_r - CNT_W'(1);
            end else begin
                count_next_s = count_r;
            end
        end

        if (issue_clear_s) begin
            clear_latch_next_s = 1'b0;
        end else if (clear_req) begin
            clear_latch_next_s = 1'b1;
        end else begin
            clear_latch_next_s = clear_latch_r;
        end

        if (clear_req) begin
            overflow_next_s = 1'b0;
        end else if (drop_s) begin
            overflow_next_s = 1'b1;
        end else begin
            overflow_next_s = overflow_r;
        end

        if (issue_insert_s) begin
            new_record_next_s = head_s;
        end else begin
            new_record_next_s = new_record_r;
        end

        busy_next_s = (state_next_s != IDLE) || (count_next_s != {CNT_W{1'b0}}) ||
                      clear_latch_next_s;
    end

    // State, pointer and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            timer_r       <= {TMR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
            clear_latch_r <= 1'b0;
            insert_r      <= 1'b0;
            clear_r       <= 1'b0;
            new_record_r  <= {REC_W{1'b0}};
            overflow_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            timer_r       <= timer_next_s;
            wr_ptr_r      <= wr_ptr_next_s;
            rd_ptr_r      <= rd_ptr_next_s;
            count_r       <= count_next_s;
            clear_latch_r <= clear_latch_next_s;
            insert_r      <= issue_insert_s;
            clear_r       <= issue_clear_s;
            new_record_r  <= new_record_next_s;
            overflow_r    <= overflow_next_s;
            busy_r        <= busy_next_s;
        end
    end

    // FIFO storage; contents need no reset since count_r gates every read.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= lap_record;
        end
    end

    assign insert     = insert_r;
    assign clear      = clear_r;
    assign new_record = new_record_r;
    assign pending    = count_r;
    assign overflow   = overflow_r;
    assign busy       = busy_r;
endmodule

// File: tb/tb_lcd_record_scheduler.sv
// Self-checking bench for lcd_record_scheduler: scenario tasks plus a randomized
// queue/overflow/clear model compared against the pulses seen at the bridge side.
module tb_lcd_record_scheduler;
    localparam int REC_W       = 32;
    localparam int DEPTH       = 4;
    localparam int ACK_TIMEOUT = 15;
    localparam int CNT_W       = $clog2(DEPTH + 1);

    logic               clock = 1'b0;
    logic               reset;
    logic               lap_req;
    logic [REC_W-1:0]   lap_record;
    logic               clear_req;
    logic               lcd_busy;
    logic               insert;
    logic [REC_W-1:0]   new_record;
    logic               clear;
    logic [CNT_W-1:0]   pending;
    logic               overflow;
    logic               busy;

    int total = 0;
    int bad   = 0;

    logic force_busy = 1'b0;
    logic auto_en    = 1'b0;
    logic auto_busy  = 1'b0;
    assign lcd_busy = force_busy | auto_busy;

    lcd_record_scheduler #(.REC_W(REC_W), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clock(clock), .reset(reset), .lap_req(lap_req), .lap_record(lap_record),
        .clear_req(clear_req), .lcd_busy(lcd_busy), .insert(insert),
        .new_record(new_record), .clear(clear), .pending(pending),
        .overflow(overflow), .busy(busy)
    );

    always #5 clock = ~clock;

    // Bridge-side log of every command pulse.
    logic [REC_W-1:0] ins_q[$];
    int               ins_t[$];
    bit               ins_ok[$];
    int               clr_cnt   = 0;
    int               both_cnt  = 0;
    int               cyc       = 0;
    bit               busy_seen = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (insert === 1'b1) begin
            ins_q.push_back(new_record);
            ins_t.push_back(cyc);
            ins_ok.push_back(busy_seen);
            busy_seen = 1'b0;
        end
        if (clear === 1'b1) clr_cnt++;
        if (insert === 1'b1 && clear === 1'b1) both_cnt++;
        if (lcd_busy === 1'b1) busy_seen = 1'b1;
    end

    // Simple bridge responder: busy rises a few cycles after a command, then falls.
    int dly  = 0;
    int hold = 0;
    bit armed = 1'b0;
    always @(posedge clock) begin
        if (reset === 1'b1) begin
            armed     <= 1'b0;
            auto_busy <= 1'b0;
        end else if (auto_en && (insert === 1'b1 || clear === 1'b1) && !armed) begin
            armed <= 1'b1;
            dly   <= $urandom_range(0, 5);
            hold  <= $urandom_range(1, 6);
        end else if (armed) begin
            if (dly > 0) dly <= dly - 1;
            else if (!auto_busy) auto_busy <= 1'b1;
            else if (hold > 0) hold <= hold - 1;
            else begin
                auto_busy <= 1'b0;
                armed     <= 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        ins_q.delete();
        ins_t.delete();
        ins_ok.delete();
        clr_cnt   = 0;
        busy_seen = 1'b0;
    endtask

    task automatic pulse_lap(input logic [REC_W-1:0] r);
        lap_req    = 1'b1;
        lap_record = r;
        tick();
        lap_req    = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit timed_out);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        timed_out = (busy !== 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({insert, clear, overflow, busy} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: insert/clear/overflow/busy=%b required 0000",
                     {insert, clear, overflow, busy});
        end
        total++;
        if (pending !== CNT_W'(0)) begin
            bad++;
            $display("FAIL reset_pending: got %0d required 0", pending);
        end
        total++;
        if (new_record !== 32'h0000_0000) begin
            bad++;
            $display("FAIL reset_new_record: got %h required 0", new_record);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_insert();
        bit to;
        auto_en = 1'b1;
        clear_logs();
        pulse_lap(32'h0012_0345);
        total++;
        if (insert !== 1'b1) begin
            bad++;
            $display("FAIL single_insert_pulse: got %b required 1", insert);
        end
        total++;
        if (new_record !== 32'h0012_0345) begin
            bad++;
            $display("FAIL single_new_record: got %h required 00120345", new_record);
        end
        total++;
        if (pending !== CNT_W'(0)) begin
            bad++;
            $display("FAIL single_pending: got %0d required 0", pending);
        end
        wait_idle(200, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL single_idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic test_queue_order();
        logic [REC_W-1:0] r[3];
        bit to;
        clear_logs();
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            r[i] = $urandom;
            pulse_lap(r[i]);
            repeat (3) tick();
        end
        repeat (88) tick();
        total++;
        if (pending !== CNT_W'(3) || ins_q.size() != 0) begin
            bad++;
            $display("FAIL queue_hold: pending=%0d inserts=%0d required 3 and 0",
                     pending, ins_q.size());
        end
        force_busy = 1'b0;
        wait_idle(500, to);
        total++;
        if (to || ins_q.size() != 3) begin
            bad++;
            $display("FAIL queue_count: inserts=%0d timeout=%0b required 3", ins_q.size(), to);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (ins_q[i] !== r[i] || !ins_ok[i]) begin
                    bad++;
                    $display("FAIL queue_order[%0d]: got %h (busy_between=%0b) required %h",
                             i, ins_q[i], ins_ok[i], r[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [REC_W-1:0] r[6];
        bit to;
        clear_logs();
        force_busy = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            r[i] = $urandom;
            pulse_lap(r[i]);
        end
        tick();
        total++;
        if (pending !== CNT_W'(DEPTH) || overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_fill: pending=%0d overflow=%b required %0d and 1",
                     pending, overflow, DEPTH);
        end
        force_busy = 1'b0;
        wait_idle(500, to);
        total++;
        if (to || ins_q.size() != DEPTH) begin
            bad++;
            $display("FAIL overflow_count: inserts=%0d required %0d", ins_q.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                total++;
                if (ins_q[i] !== r[i]) begin
                    bad++;
                    $display("FAIL overflow_order[%0d]: got %h required %h", i, ins_q[i], r[i]);
                end
            end
        end
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_sticky: got %b required 1", overflow);
        end
    endtask

    task automatic test_clear_in_flight();
        bit to;
        auto_en = 1'b0;
        clear_logs();
        lap_req    = 1'b1;
        lap_record = $urandom;
        tick();
        lap_req    = 1'b0;
        force_busy = 1'b1;
        repeat (3) tick();
        pulse_lap($urandom);
        pulse_lap($urandom);
        total++;
        if (pending !== CNT_W'(2)) begin
            bad++;
            $display("FAIL clear_pre_pending: got %0d required 2", pending);
        end
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        total++;
        if (pending !== CNT_W'(0) || overflow !== 1'b0) begin
            bad++;
            $display("FAIL clear_flush: pending=%0d overflow=%b required 0 and 0",
                     pending, overflow);
        end
        repeat (5) tick();
        total++;
        if (clr_cnt != 0) begin
            bad++;
            $display("FAIL clear_while_busy: clears=%0d required 0", clr_cnt);
        end
        force_busy = 1'b0;
        wait_idle(200, to);
        total++;
        if (to || clr_cnt != 1 || ins_q.size() != 1) begin
            bad++;
            $display("FAIL clear_after_busy: clears=%0d inserts=%0d required 1 and 1",
                     clr_cnt, ins_q.size());
        end
    endtask

    task automatic test_timeout();
        logic [REC_W-1:0] r0, r1;
        bit to;
        auto_en = 1'b0;
        clear_logs();
        r0 = $urandom;
        r1 = $urandom;
        force_busy = 1'b1;
        tick();
        pulse_lap(r0);
        pulse_lap(r1);
        force_busy = 1'b0;
        wait_idle(200, to);
        total++;
        if (to || ins_q.size() != 2) begin
            bad++;
            $display("FAIL timeout_count: inserts=%0d required 2", ins_q.size());
        end else begin
            total++;
            if (ins_q[0] !== r0 || ins_q[1] !== r1) begin
                bad++;
                $display("FAIL timeout_order: got %h %h required %h %h",
                         ins_q[0], ins_q[1], r0, r1);
            end
            total++;
            if (ins_t[1] - ins_t[0] < ACK_TIMEOUT + 1 || ins_t[1] - ins_t[0] > ACK_TIMEOUT + 2) begin
                bad++;
                $display("FAIL timeout_gap: got %0d cycles required %0d..%0d",
                         ins_t[1] - ins_t[0], ACK_TIMEOUT + 1, ACK_TIMEOUT + 2);
            end
        end
    endtask

    task automatic test_lap_and_clear();
        bit to;
        auto_en = 1'b1;
        clear_logs();
        lap_req    = 1'b1;
        clear_req  = 1'b1;
        lap_record = $urandom;
        tick();
        lap_req   = 1'b0;
        clear_req = 1'b0;
        total++;
        if (clear !== 1'b1 || insert !== 1'b0 || pending !== CNT_W'(0)) begin
            bad++;
            $display("FAIL lap_clear_same: clear=%b insert=%b pending=%0d required 1 0 0",
                     clear, insert, pending);
        end
        wait_idle(200, to);
        total++;
        if (to || clr_cnt != 1 || ins_q.size() != 0) begin
            bad++;
            $display("FAIL lap_clear_total: clears=%0d inserts=%0d required 1 and 0",
                     clr_cnt, ins_q.size());
        end
    endtask

    task automatic test_reset_mid();
        auto_en = 1'b0;
        clear_logs();
        lap_req    = 1'b1;
        lap_record = $urandom;
        tick();
        lap_req    = 1'b0;
        force_busy = 1'b1;
        repeat (3) tick();
        pulse_lap($urandom);
        reset = 1'b1;
        tick();
        total++;
        if ({insert, clear, overflow, busy} !== 4'b0000 || pending !== CNT_W'(0) ||
            new_record !== 32'h0000_0000) begin
            bad++;
            $display("FAIL reset_mid: ctrl=%b pending=%0d new_record=%h required all 0",
                     {insert, clear, overflow, busy}, pending, new_record);
        end
        reset      = 1'b0;
        force_busy = 1'b0;
        repeat (40) tick();
        total++;
        if (ins_q.size() != 1 || clr_cnt != 0) begin
            bad++;
            $display("FAIL reset_mid_abandon: inserts=%0d clears=%0d required 1 and 0",
                     ins_q.size(), clr_cnt);
        end
    endtask

    task automatic test_random();
        logic [REC_W-1:0] mq[$];
        logic [REC_W-1:0] r;
        bit ovf = 1'b0;
        bit clr_exp;
        bit to;
        int n;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        auto_en = 1'b1;
        for (int round = 0; round < 20; round++) begin
            clear_logs();
            mq.delete();
            clr_exp    = 1'b0;
            force_busy = 1'b1;
            tick();
            n = $urandom_range(0, 7);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    clear_req = 1'b1;
                    tick();
                    clear_req = 1'b0;
                    mq.delete();
                    ovf     = 1'b0;
                    clr_exp = 1'b1;
                end else begin
                    r = $urandom;
                    pulse_lap(r);
                    if (mq.size() < DEPTH) mq.push_back(r);
                    else ovf = 1'b1;
                end
                repeat ($urandom_range(0, 2)) tick();
            end
            total++;
            if (pending !== CNT_W'(mq.size()) || overflow !== ovf) begin
                bad++;
                $display("FAIL rand_queue[%0d]: pending=%0d overflow=%b required %0d and %b",
                         round, pending, overflow, mq.size(), ovf);
            end
            force_busy = 1'b0;
            wait_idle(1000, to);
            total++;
            if (to || ins_q.size() != mq.size() || clr_cnt != int'(clr_exp)) begin
                bad++;
                $display("FAIL rand_drain[%0d]: inserts=%0d clears=%0d required %0d and %0d",
                         round, ins_q.size(), clr_cnt, mq.size(), clr_exp);
            end else begin
                for (int i = 0; i < mq.size(); i++) begin
                    total++;
                    if (ins_q[i] !== mq[i]) begin
                        bad++;
                        $display("FAIL rand_record[%0d][%0d]: got %h required %h",
                                 round, i, ins_q[i], mq[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        lap_req    = 1'b0;
        clear_req  = 1'b0;
        lap_record = '0;
        test_reset();
        test_single_insert();
        test_queue_order();
        test_overflow();
        test_clear_in_flight();
        test_timeout();
        test_lap_and_clear();
        test_reset_mid();
        test_random();
        total++;
        if (both_cnt != 0) begin
            bad++;
            $display("FAIL insert_clear_overlap: got %0d cycles required 0", both_cnt);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
